// File: rtl/fbc_sched_pkg.sv
// rtl/fbc_sched_pkg.sv - shared types, descriptor layout and validity check for the layer scheduler
package fbc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CHECK  = 3'd2,
        LAUNCH = 3'd3,
        RUN    = 3'd4,
        GAP    = 3'd5,
        FIN    = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam int DESC_W   = 72;
    localparam int K_LSB    = 0;
    localparam int K_W      = 4;
    localparam int S_LSB    = 4;
    localparam int S_W      = 2;
    localparam int IFW_LSB  = 6;
    localparam int IFC_LSB  = 14;
    localparam int OFW_LSB  = 22;
    localparam int OFC_LSB  = 30;
    localparam int DIM_W    = 8;
    localparam int BASE_LSB = 38;
    localparam int BASE_W   = 32;

    // A descriptor the generator can run: odd kernel, nonzero stride, channel
    // counts on the generator's lane granularity, and the kernel fits the input.
    function automatic logic desc_valid(input logic [DESC_W-1:0] d);
        logic [K_W-1:0]   k;
        logic [S_W-1:0]   s;
        logic [DIM_W-1:0] ifw;
        logic [DIM_W-1:0] ifc;
        logic [DIM_W-1:0] ofw;
        logic [DIM_W-1:0] ofc;
        logic             ok;
        k   = d[K_LSB   +: K_W];
        s   = d[S_LSB   +: S_W];
        ifw = d[IFW_LSB +: DIM_W];
        ifc = d[IFC_LSB +: DIM_W];
        ofw = d[OFW_LSB +: DIM_W];
        ofc = d[OFC_LSB +: DIM_W];
        ok  = 1'b1;
        if (k == '0 || !k[0])                 ok = 1'b0;
        if (s == '0)                          ok = 1'b0;
        if (ifc == '0 || ifc[1:0] != 2'b00)   ok = 1'b0;
        if (ofc == '0 || ofc[3:0] != 4'b0000) ok = 1'b0;
        if (ofw == '0)                        ok = 1'b0;
        if (ifw < {4'b0000, k})               ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/conv_desc_table.sv
// rtl/conv_desc_table.sv - layer descriptor register file, one write port, registered read port
module conv_desc_table
    import fbc_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DESC_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DESC_W-1:0] rd_data
);

    logic [DESC_W-1:0] mem [DEPTH];

    // Storage and read register; reset empties every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_data <= '0;
        end else begin
            if (we) mem[wr_idx] <= wr_data;
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - runs the conv address generator layer by layer; FBC_SCHED_PERF_EN adds a RUN cycle counter
module conv_layer_scheduler
    import fbc_sched_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DESC_W-1:0] cfg_desc,
    input  logic [IDX_W:0]    num_layers,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDX_W-1:0]  cur_layer,
    output logic              ag_ready,
    output logic [3:0]        ag_kernel_w,
    output logic [1:0]        ag_stride,
    output logic [7:0]        ag_ifm_w,
    output logic [7:0]        ag_ifm_c,
    output logic [7:0]        ag_ofm_w,
    output logic [7:0]        ag_ofm_c,
    output logic [ADDR_W-1:0] ag_addr_in,
    input  logic              ag_done,
    output logic [31:0]       perf_cycles
);

    localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(MAX_LAYERS);
    localparam logic [IDX_W:0] ONE_N = (IDX_W+1)'(1);

    state_t            state, state_nxt;
    logic [IDX_W:0]    num_q;
    logic [IDX_W-1:0]  cur_nxt;
    logic [DESC_W-1:0] rd_desc;
    logic              desc_ok;
    logic              last_layer;
    logic              accept;

    assign accept     = (state == IDLE) && start;
    assign last_layer = ({1'b0, cur_layer} == (num_q - ONE_N));
    assign busy       = (state != IDLE) && (state != ERR);
    assign done       = (state == FIN);
    assign ag_ready   = (state == LAUNCH);

    // The read port is addressed with the next layer index so the descriptor
    // is already on rd_desc during LOAD.
    conv_desc_table #(
        .DEPTH (MAX_LAYERS),
        .IDX_W (IDX_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (cfg_we && (state == IDLE)),
        .wr_idx  (cfg_idx),
        .wr_data (cfg_desc),
        .rd_idx  (cur_nxt),
        .rd_data (rd_desc)
    );

    // Next-state and next layer index.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_layer;
        case (state)
            IDLE:   if (start) begin
                        cur_nxt   = '0;
                        state_nxt = (num_layers == '0) ? FIN : LOAD;
                    end
            LOAD:   state_nxt = CHECK;
            CHECK:  state_nxt = desc_ok ? LAUNCH : ERR;
            LAUNCH: state_nxt = RUN;
            RUN:    if (ag_done) state_nxt = GAP;
            GAP:    if (last_layer) begin
                        state_nxt = FIN;
                    end else begin
                        cur_nxt   = cur_layer + 1'b1;
                        state_nxt = LOAD;
                    end
            FIN:    state_nxt = IDLE;
            ERR:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, layer index, layer count latch and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_layer <= '0;
            num_q     <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_layer <= cur_nxt;
            if (accept) begin
                num_q <= (num_layers > MAX_N) ? MAX_N : num_layers;
                err   <= 1'b0;
            end else if (state == CHECK && !desc_ok) begin
                err   <= 1'b1;
            end
        end
    end

    // Generator config captured in LOAD; held until the next LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ag_kernel_w <= '0;
            ag_stride   <= '0;
            ag_ifm_w    <= '0;
            ag_ifm_c    <= '0;
            ag_ofm_w    <= '0;
            ag_ofm_c    <= '0;
            ag_addr_in  <= '0;
            desc_ok     <= 1'b0;
        end else if (state == LOAD) begin
            ag_kernel_w <= rd_desc[K_LSB   +: K_W];
            ag_stride   <= rd_desc[S_LSB   +: S_W];
            ag_ifm_w    <= rd_desc[IFW_LSB +: DIM_W];
            ag_ifm_c    <= rd_desc[IFC_LSB +: DIM_W];
            ag_ofm_w    <= rd_desc[OFW_LSB +: DIM_W];
            ag_ofm_c    <= rd_desc[OFC_LSB +: DIM_W];
            ag_addr_in  <= ADDR_W'(rd_desc[BASE_LSB +: BASE_W]);
            desc_ok     <= desc_valid(rd_desc);
        end
    end

`ifdef FBC_SCHED_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_inc;

    assign perf_inc = (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;

    // Count RUN cycles of the current layer; publish when the layer finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (state == LAUNCH)   perf_cnt <= '0;
            else if (state == RUN) perf_cnt <= perf_inc;
            if (state == RUN && ag_done) perf_cycles <= perf_inc;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb/tb_conv_layer_scheduler.sv - self-checking bench for conv_layer_scheduler
module tb_conv_layer_scheduler;

    typedef struct packed {
        logic [1:0]  pad;
        logic [31:0] base;
        logic [7:0]  oc;
        logic [7:0]  ow;
        logic [7:0]  ic;
        logic [7:0]  iw;
        logic [1:0]  s;
        logic [3:0]  k;
    } desc_t;

    typedef struct {
        desc_t d;
        bit    valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [71:0] cfg_desc = '0;
    logic [3:0]  num_layers = '0;
    logic        start = 1'b0;
    logic        ag_done = 1'b0;
    logic        busy, done, err, ag_ready;
    logic [2:0]  cur_layer;
    logic [3:0]  ag_kernel_w;
    logic [1:0]  ag_stride;
    logic [7:0]  ag_ifm_w, ag_ifm_c, ag_ofm_w, ag_ofm_c;
    logic [31:0] ag_addr_in;
    logic [31:0] perf_cycles;

    int    n_chk = 0;
    int    n_fail = 0;
    int    ready_cnt = 0;
    desc_t shadow [8];
    vec_t  vecs [12];

    conv_layer_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_desc    (cfg_desc),
        .num_layers  (num_layers),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cur_layer   (cur_layer),
        .ag_ready    (ag_ready),
        .ag_kernel_w (ag_kernel_w),
        .ag_stride   (ag_stride),
        .ag_ifm_w    (ag_ifm_w),
        .ag_ifm_c    (ag_ifm_c),
        .ag_ofm_w    (ag_ofm_w),
        .ag_ofm_c    (ag_ofm_c),
        .ag_addr_in  (ag_addr_in),
        .ag_done     (ag_done),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ag_ready === 1'b1) ready_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit hit, bench expected to finish earlier");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic desc_t mk(input int k, input int s, input int iw, input int ic,
                                 input int ow, input int oc, input logic [31:0] base);
        desc_t d;
        d.pad = '0; d.base = base;
        d.k = 4'(k); d.s = 2'(s); d.iw = 8'(iw); d.ic = 8'(ic); d.ow = 8'(ow); d.oc = 8'(oc);
        return d;
    endfunction

    function automatic bit ref_valid(input desc_t d);
        int k, s, iw, ic, ow, oc;
        k = int'(d.k); s = int'(d.s); iw = int'(d.iw);
        ic = int'(d.ic); ow = int'(d.ow); oc = int'(d.oc);
        return (k % 2 == 1) && (s > 0) && (ic > 0) && (ic % 4 == 0) &&
               (oc > 0) && (oc % 16 == 0) && (ow > 0) && (iw >= k);
    endfunction

    function automatic logic [31:0] exp_perf(input int delay);
`ifdef FBC_SCHED_PERF_EN
        return 32'(delay);
`else
        return 32'(delay - delay);
`endif
    endfunction

    task automatic write_slot(input int idx, input desc_t d);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_desc = d;
        tick();
        cfg_we = 1'b0;
        shadow[idx] = d;
    endtask

    // Runs one job against the shadow table. poke drives start and a table
    // write during layer 0's RUN, both of which must have no effect.
    task automatic run_job(input int nl, input int delay, input bit poke);
        int          layers;
        int          launched;
        int          r0;
        bit          stopped;
        logic [71:0] junk;
        layers   = (nl > 8) ? 8 : nl;
        launched = 0;
        stopped  = 0;
        r0       = ready_cnt;
        junk     = {72{1'b1}};
        num_layers = 4'(nl); start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_cleared_by_start", err, 0);
        if (layers == 0) begin
            chk("zero_layers_done", done, 1);
            tick();
            chk("zero_layers_idle", busy, 0);
        end
        for (int i = 0; i < layers && !stopped; i++) begin
            chk("load_no_ready", ag_ready, 0);
            tick();
            chk("check_no_ready", ag_ready, 0);
            tick();
            if (!ref_valid(shadow[i])) begin
                chk("err_set", err, 1);
                chk("err_busy_low", busy, 0);
                chk("err_layer", cur_layer, i);
                tick();
                chk("err_sticky", err, 1);
                stopped = 1;
            end else begin
                launched++;
                chk("launch_ready", ag_ready, 1);
                chk("launch_layer", cur_layer, i);
                chk("launch_cfg", {ag_addr_in, ag_ofm_c, ag_ofm_w, ag_ifm_c, ag_ifm_w, ag_stride, ag_kernel_w},
                    {2'b00, shadow[i][69:0]});
                for (int j = 1; j <= delay; j++) begin
                    tick();
                    if (j == 1) chk("ready_one_cycle", ag_ready, 0);
                    start  = poke && (i == 0) && (j == 1);
                    cfg_we = poke && (i == 0) && (j == 1);
                    cfg_idx = '0; cfg_desc = junk;
                    ag_done = (j == delay);
                end
                tick();
                ag_done = 1'b1;
                start = 1'b0; cfg_we = 1'b0;
                chk("gap_no_ready", ag_ready, 0);
                chk("gap_busy", busy, 1);
                chk("perf_cycles", perf_cycles, exp_perf(delay));
                tick();
                ag_done = 1'b0;
                if (i == layers - 1) begin
                    chk("fin_done", done, 1);
                    chk("fin_busy", busy, 1);
                    tick();
                    chk("idle_busy", busy, 0);
                    chk("idle_done", done, 0);
                    chk("fin_layer", cur_layer, i);
                end else begin
                    chk("next_layer", cur_layer, i + 1);
                end
            end
        end
        chk("ready_pulses", ready_cnt - r0, launched);
    endtask

    initial begin
        desc_t d;
        int    nl, dly;

        vecs[0].d  = mk(3, 1, 8, 4, 6, 16, 32'h100);      vecs[0].valid  = 1;
        vecs[1].d  = mk(0, 1, 8, 4, 6, 16, 32'h200);      vecs[1].valid  = 0;
        vecs[2].d  = mk(2, 1, 8, 4, 6, 16, 32'h300);      vecs[2].valid  = 0;
        vecs[3].d  = mk(3, 0, 8, 4, 6, 16, 32'h400);      vecs[3].valid  = 0;
        vecs[4].d  = mk(3, 1, 8, 0, 6, 16, 32'h500);      vecs[4].valid  = 0;
        vecs[5].d  = mk(3, 1, 8, 6, 6, 16, 32'h600);      vecs[5].valid  = 0;
        vecs[6].d  = mk(3, 1, 8, 4, 6, 0, 32'h700);       vecs[6].valid  = 0;
        vecs[7].d  = mk(3, 1, 8, 4, 6, 8, 32'h800);       vecs[7].valid  = 0;
        vecs[8].d  = mk(3, 1, 8, 4, 0, 16, 32'h900);      vecs[8].valid  = 0;
        vecs[9].d  = mk(3, 1, 2, 4, 6, 16, 32'hA00);      vecs[9].valid  = 0;
        vecs[10].d = mk(3, 2, 3, 4, 1, 16, 32'hB00);      vecs[10].valid = 1;
        vecs[11].d = mk(15, 3, 255, 252, 255, 240, 32'hFFFF_FFF0); vecs[11].valid = 1;

        for (int i = 0; i < 8; i++) shadow[i] = '0;

        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_cur_layer", cur_layer, 0);
        chk("reset_ag_ready", ag_ready, 0);
        chk("reset_cfg", {ag_addr_in, ag_ofm_c, ag_ofm_w, ag_ifm_c, ag_ifm_w, ag_stride, ag_kernel_w}, 0);
        chk("reset_perf", perf_cycles, 0);
        rst_n = 1'b1;
        tick();

        // descriptor rule table, one single-layer job per entry
        for (int v = 0; v < 12; v++) begin
            chk("vec_rule", ref_valid(vecs[v].d), vecs[v].valid);
            write_slot(0, vecs[v].d);
            run_job(1, 2 + (v % 3), 0);
        end

        // three valid layers, with start and table write attempted during RUN
        write_slot(0, mk(3, 1, 8, 4, 6, 16, 32'h1000));
        write_slot(1, mk(5, 2, 16, 8, 8, 32, 32'h2000));
        write_slot(2, mk(1, 1, 4, 12, 4, 48, 32'h3000));
        run_job(3, 4, 1);
        run_job(3, 1, 0);

        // invalid middle layer, then a rerun clears err
        write_slot(1, mk(5, 2, 16, 6, 8, 32, 32'h2000));
        run_job(3, 3, 0);
        write_slot(1, mk(5, 2, 16, 8, 8, 32, 32'h2000));
        run_job(3, 2, 0);

        run_job(0, 1, 0);

        // clamp above MAX_LAYERS
        for (int i = 0; i < 8; i++) write_slot(i, mk(3, 1, 8 + i, 4, 6, 16, 32'h4000 + 32'(i)));
        run_job(12, 1, 0);

        run_job(1, 50, 0);

        // randomized tables and job sizes
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 8; i++) begin
                d = mk(2 * $urandom_range(0, 7) + 1, $urandom_range(1, 3), 0, 4 * $urandom_range(1, 63),
                       $urandom_range(1, 255), 16 * $urandom_range(1, 15), $urandom);
                d.iw = 8'($urandom_range(int'(d.k), 255));
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 5))
                        0: d.k  = 4'(2 * $urandom_range(0, 7));
                        1: d.s  = 2'b00;
                        2: d.ic = d.ic | 8'($urandom_range(1, 3));
                        3: d.oc = 8'h00;
                        4: d.ow = 8'h00;
                        default: d.iw = 8'(d.k) - 8'd1;
                    endcase
                end
                write_slot(i, d);
            end
            nl  = $urandom_range(0, 10);
            dly = $urandom_range(1, 6);
            run_job(nl, dly, 0);
        end

        // asynchronous reset during layer 1 RUN
        for (int i = 0; i < 3; i++) write_slot(i, mk(3, 1, 8, 4, 6, 16, 32'h5000 + 32'(i)));
        num_layers = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        ag_done = 1'b1;
        tick();
        ag_done = 1'b0;
        repeat (4) tick();
        chk("pre_reset_layer1_busy", busy, 1);
        chk("pre_reset_layer1_idx", cur_layer, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_cur_layer", cur_layer, 0);
        chk("mid_reset_outputs", {done, err, ag_ready, ag_addr_in, ag_kernel_w, perf_cycles}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) shadow[i] = '0;
        tick();
        run_job(1, 1, 0);
        chk("empty_table_err", err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
